// File: rtl/maq_pkg.sv
// rtl/maq_pkg.sv - shared types, constants and BCD hour helpers for the hours stage
package maq_pkg;

    typedef enum logic {RUN, SET} maqh_state_t;

    localparam logic [1:0] HOUR_MAX_MSD        = 2'd2;
    localparam logic [3:0] HOUR_MAX_LSD_AT_MAX = 4'd3;

    typedef struct packed {
        logic [1:0] msd;
        logic [3:0] lsd;
    } hour_t;

    typedef struct packed {
        logic  pm;
        hour_t hr;
    } hour12_t;

    function automatic hour_t bcd_inc(input hour_t h);
        hour_t r;
        r = h;
        if (h.msd == HOUR_MAX_MSD && h.lsd == HOUR_MAX_LSD_AT_MAX) begin
            r = '0;
        end else if (h.lsd == 4'd9) begin
            r.lsd = 4'd0;
            r.msd = h.msd + 2'd1;
        end else begin
            r.lsd = h.lsd + 4'd1;
        end
        return r;
    endfunction

    function automatic hour_t bcd_dec(input hour_t h);
        hour_t r;
        r = h;
        if (h.msd == 2'd0 && h.lsd == 4'd0) begin
            r.msd = HOUR_MAX_MSD;
            r.lsd = HOUR_MAX_LSD_AT_MAX;
        end else if (h.lsd == 4'd0) begin
            r.lsd = 4'd9;
            r.msd = h.msd - 2'd1;
        end else begin
            r.lsd = h.lsd - 4'd1;
        end
        return r;
    endfunction

    // Midnight and noon both display as 12; pm covers 12..23
    function automatic hour12_t to_12h(input hour_t h);
        hour12_t r;
        int      v;
        int      v12;
        v   = int'(h.msd) * 10 + int'(h.lsd);
        v12 = v % 12;
        if (v12 == 0) v12 = 12;
        r.pm     = (v >= 12);
        r.hr.msd = 2'(v12 / 10);
        r.hr.lsd = 4'(v12 % 10);
        return r;
    endfunction

endpackage

// File: rtl/maq_h_if.sv
// rtl/maq_h_if.sv - hours stage signal bundle; optional maqh_pm under MAQH_12H_EN
interface maq_h_if;
    logic       maqh_inc_hora;
    logic       maqh_set;
    logic       maqh_up;
    logic       maqh_down;
    logic [3:0] maqh_lsd;
    logic [1:0] maqh_msd;
    logic       maqh_inc_dia;
    logic       maqh_setting;
    logic       maqh_blink;
`ifdef MAQH_12H_EN
    logic       maqh_pm;

    modport master (
        output maqh_inc_hora, maqh_set, maqh_up, maqh_down,
        input  maqh_lsd, maqh_msd, maqh_inc_dia, maqh_setting, maqh_blink, maqh_pm
    );
    modport slave (
        input  maqh_inc_hora, maqh_set, maqh_up, maqh_down,
        output maqh_lsd, maqh_msd, maqh_inc_dia, maqh_setting, maqh_blink, maqh_pm
    );
`else
    modport master (
        output maqh_inc_hora, maqh_set, maqh_up, maqh_down,
        input  maqh_lsd, maqh_msd, maqh_inc_dia, maqh_setting, maqh_blink
    );
    modport slave (
        input  maqh_inc_hora, maqh_set, maqh_up, maqh_down,
        output maqh_lsd, maqh_msd, maqh_inc_dia, maqh_setting, maqh_blink
    );
`endif
endinterface

// File: rtl/maqh_btn_rpt.sv
// rtl/maqh_btn_rpt.sv - button rising-edge detector with REPEAT_CYC auto-repeat step pulse
module maqh_btn_rpt #(
    parameter int REPEAT_CYC = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic hold,
    output logic edge_pulse,
    output logic step
);
    localparam int W = $clog2(REPEAT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(REPEAT_CYC - 1);

    logic         prev;
    logic [W-1:0] cnt;

    // cnt is zero on the press cycle and every REPEAT_CYC cycles after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= btn;
            if (btn && !hold) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign edge_pulse = btn & ~prev;
    assign step       = btn & ~hold & (cnt == '0);
endmodule

// File: rtl/maq_h.sv
// rtl/maq_h.sv - hours stage: BCD 00-23 count, day carry, set mode with repeat and blink; option MAQH_12H_EN
module maq_h
    import maq_pkg::*;
#(
    parameter int REPEAT_CYC = 25000000,
    parameter int BLINK_CYC  = 12500000
) (
    input  logic     maqh_clock,
    input  logic     reset,
    maq_h_if.slave   bus
);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    maqh_state_t   state;
    hour_t         hour;
    logic          inc_q;
    logic [BW-1:0] blink_cnt;
    logic          inc_dia;
    logic          setting;
    logic          blink;

    logic carry;
    logic both;
    logic set_edge;
    logic up_step;
    logic down_step;
    logic set_step_unused;
    logic up_edge_unused;
    logic down_edge_unused;

    assign carry = inc_q & ~bus.maqh_inc_hora;
    assign both  = bus.maqh_up & bus.maqh_down;

    maqh_btn_rpt #(.REPEAT_CYC(REPEAT_CYC)) u_set (
        .clk(maqh_clock), .rst(reset), .btn(bus.maqh_set), .hold(1'b0),
        .edge_pulse(set_edge), .step(set_step_unused)
    );
    maqh_btn_rpt #(.REPEAT_CYC(REPEAT_CYC)) u_up (
        .clk(maqh_clock), .rst(reset), .btn(bus.maqh_up), .hold(both),
        .edge_pulse(up_edge_unused), .step(up_step)
    );
    maqh_btn_rpt #(.REPEAT_CYC(REPEAT_CYC)) u_down (
        .clk(maqh_clock), .rst(reset), .btn(bus.maqh_down), .hold(both),
        .edge_pulse(down_edge_unused), .step(down_step)
    );

    always_ff @(posedge maqh_clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            hour      <= '0;
            inc_q     <= 1'b0;
            blink_cnt <= '0;
            inc_dia   <= 1'b0;
            setting   <= 1'b0;
            blink     <= 1'b1;
        end else begin
            inc_q   <= bus.maqh_inc_hora;
            inc_dia <= 1'b0;
            case (state)
                RUN: begin
                    // A carry coinciding with the set press still lands before SET
                    if (carry) begin
                        hour <= bcd_inc(hour);
                        if (hour.msd == HOUR_MAX_MSD && hour.lsd == HOUR_MAX_LSD_AT_MAX) begin
                            inc_dia <= 1'b1;
                        end
                    end
                    if (set_edge) begin
                        state     <= SET;
                        setting   <= 1'b1;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end
                end
                SET: begin
                    if (set_edge) begin
                        state   <= RUN;
                        setting <= 1'b0;
                        blink   <= 1'b1;
                    end else begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                        if (up_step) begin
                            hour <= bcd_inc(hour);
                        end else if (down_step) begin
                            hour <= bcd_dec(hour);
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef MAQH_12H_EN
    hour12_t disp;
    assign disp        = to_12h(hour);
    assign bus.maqh_lsd = disp.hr.lsd;
    assign bus.maqh_msd = disp.hr.msd;
    assign bus.maqh_pm  = disp.pm;
`else
    assign bus.maqh_lsd = hour.lsd;
    assign bus.maqh_msd = hour.msd;
`endif
    assign bus.maqh_inc_dia = inc_dia;
    assign bus.maqh_setting = setting;
    assign bus.maqh_blink   = blink;
endmodule

// File: tb/tb_maq_h.sv
// tb/tb_maq_h.sv - self-checking bench for maq_h (vector table, corner sequences, random vs model)
module tb_maq_h;
    localparam int R = 8;
    localparam int B = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    maq_h_if bus();
    maq_h #(.REPEAT_CYC(R), .BLINK_CYC(B)) dut (.maqh_clock(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic inc; logic set; logic up; logic down;
        int   hour; logic dia; logic setting; logic blink;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic chk_hour(input string name, input int h);
        int dh;
        dh = h;
`ifdef MAQH_12H_EN
        dh = (h % 12 == 0) ? 12 : h % 12;
        chk({name, "_pm"}, int'(bus.maqh_pm), (h >= 12) ? 1 : 0);
`endif
        chk({name, "_msd"}, int'(bus.maqh_msd), dh / 10);
        chk({name, "_lsd"}, int'(bus.maqh_lsd), dh % 10);
    endtask

    task automatic chk_all(input string name, input int h, input int dia, input int st, input int bl);
        chk_hour(name, h);
        chk({name, "_dia"}, int'(bus.maqh_inc_dia), dia);
        chk({name, "_setting"}, int'(bus.maqh_setting), st);
        chk({name, "_blink"}, int'(bus.maqh_blink), bl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic inc, input logic set, input logic up, input logic down);
        bus.maqh_inc_hora = inc;
        bus.maqh_set      = set;
        bus.maqh_up       = up;
        bus.maqh_down     = down;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic goto_hour(input int h);
        do_reset();
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        for (int i = 0; i < h; i++) begin
            drive(0, 0, 1, 0); tick();
            drive(0, 0, 0, 0); tick();
        end
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
    endtask

    task automatic carry_event();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
    endtask

    initial begin
        int   hour, blink, bc, urun, drun, exp_dia;
        logic mode, pinc, pset, carry, sedge, ustep, dstep;
        logic inc, set, up, down;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 1);
        tick();
        reset = 1'b0;
        tick();
        chk_all("reset_state", 0, 0, 0, 1);

        // inc set up down | hour dia setting blink after the edge
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 1};
        tbl[1]  = '{1, 0, 0, 0,  0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 0,  1, 0, 0, 1};
        tbl[3]  = '{0, 1, 0, 0,  1, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 1,  0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0,  0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 23, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 0,  0, 0, 1, 1};
        tbl[8]  = '{0, 0, 1, 1,  0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0,  0, 0, 1, 1};
        tbl[10] = '{1, 0, 0, 0,  0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0,  0, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 0,  0, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 0,  0, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0,  1, 0, 0, 1};
        tbl[15] = '{1, 0, 0, 0,  1, 0, 0, 1};
        tbl[16] = '{0, 1, 0, 0,  2, 0, 1, 0};
        tbl[17] = '{0, 0, 0, 0,  2, 0, 1, 0};
        tbl[18] = '{0, 1, 0, 0,  2, 0, 0, 1};
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].inc, tbl[i].set, tbl[i].up, tbl[i].down);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].hour, int'(tbl[i].dia),
                    int'(tbl[i].setting), int'(tbl[i].blink));
        end

        goto_hour(9);
        chk_hour("goto09", 9);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0); tick();
            chk_hour("carry_high", 9);
        end
        drive(0, 0, 0, 0); tick();
        chk_hour("carry_09_10", 10);
        tick();
        chk_hour("carry_once", 10);

        goto_hour(23);
        carry_event();
        chk_all("wrap_23_00", 0, 1, 0, 1);
        tick();
        chk_all("wrap_pulse_end", 0, 0, 0, 1);
        goto_hour(22);
        carry_event();
        chk_all("carry_22_23", 23, 0, 0, 1);

        goto_hour(5);
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        for (int k = 0; k < 30; k++) begin
            drive(0, 0, 1, 0); tick();
            chk_hour($sformatf("repeat_k%0d", k), 6 + k / R);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0); tick();
            chk_hour("repeat_release", 9);
        end

        goto_hour(17);
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        chk_all("pre_reset_set", 18, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_set_reset", 0, 0, 0, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("after_reset_run", 0, 0, 0, 1);
        carry_event();
        chk_all("after_reset_carry", 1, 0, 0, 1);

`ifdef MAQH_12H_EN
        goto_hour(12);
        chk_all("h12_noon", 12, 0, 0, 1);
        carry_event();
        chk_all("h12_13", 13, 0, 0, 1);
`endif

        do_reset();
        hour = 0; mode = 0; blink = 1; bc = 0; pinc = 0; pset = 0; urun = 0; drun = 0;
        inc = 0; set = 0; up = 0; down = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0)  inc  = ~inc;
            if ($urandom_range(0, 39) == 0) set  = ~set;
            if ($urandom_range(0, 11) == 0) up   = ~up;
            if ($urandom_range(0, 11) == 0) down = ~down;
            drive(inc, set, up, down);
            tick();
            carry = pinc && !inc;
            pinc  = inc;
            sedge = set && !pset;
            pset  = set;
            ustep = up && !down && (urun % R == 0);
            dstep = down && !up && (drun % R == 0);
            urun  = (up && !down) ? urun + 1 : 0;
            drun  = (down && !up) ? drun + 1 : 0;
            exp_dia = 0;
            if (!mode) begin
                if (carry) begin
                    if (hour == 23) exp_dia = 1;
                    hour = (hour + 1) % 24;
                end
                if (sedge) begin
                    mode = 1; blink = 0; bc = 0;
                end
            end else if (sedge) begin
                mode = 0; blink = 1;
            end else begin
                bc++;
                if (bc == B) begin
                    bc = 0;
                    blink = 1 - blink;
                end
                if (ustep) hour = (hour + 1) % 24;
                else if (dstep) hour = (hour + 23) % 24;
            end
            chk_all($sformatf("rand%0d", n), hour, exp_dia, int'(mode), blink);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
